// File: rtl/sb_route_sequencer.sv
// sb_route_sequencer
//   Route-level controller sitting above the turn block. A task-level
//   controller loads a table of turn codes and pulses run; this block then
//   follows the line, debounces each node (all three sensors high), hands the
//   next turn code to the turn block with turn_start/turn_cmd, waits for
//   turn_done and advances until the route is exhausted or a stop code is met.
//
//   Turn codes: 000 stop, 001 forward, 010 left, 011 right, 100 U-turn.
//
//   Build option: define SB_TURN_TIMEOUT_EN to bound the time spent waiting
//   for turn_done (TIMEOUT_CYC cycles); without it TURN waits indefinitely and
//   timeout_err stays 0.
//
// Ports
//   clk_50        in   system clock, 50 MHz
//   rst           in   asynchronous reset, active-high
//   route_wr_en   in   table write strobe (accepted only while idle)
//   route_wr_addr in   table write address
//   route_wr_data in   turn code to store
//   route_len     in   entries to execute, sampled on run (clamped to depth)
//   run           in   start route from entry 0 (accepted only while idle)
//   abort         in   synchronous return to idle from any state
//   sensor_l/m/r  in   line sensors, 1 = on line
//   turn_done     in   turn completion from turn block
//   turn_start    out  start request to turn block
//   turn_cmd      out  turn code to turn/motor block
//   node_idx      out  index of the entry being executed
//   busy          out  high whenever not idle
//   route_done    out  one-cycle pulse on route completion
//   timeout_err   out  sticky turn-timeout flag
//
// State table
//   state     | meaning
//   ST_IDLE   | waiting for run; table writable
//   ST_FOLLOW | line following, debouncing all-high sensors into a node
//   ST_TURN   | turn requested for table[node_idx], waiting for turn_done
//   ST_CLEAR  | driving forward off the node until sensors leave all-high
//   ST_FINISH | one-cycle route_done pulse, then idle

module sb_route_sequencer #(
  parameter int ADDR_W      = 4,
  parameter int NODE_DEB    = 4,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic              clk_50,
  input  logic              rst,
  input  logic              route_wr_en,
  input  logic [ADDR_W-1:0] route_wr_addr,
  input  logic [2:0]        route_wr_data,
  input  logic [ADDR_W:0]   route_len,
  input  logic              run,
  input  logic              abort,
  input  logic              sensor_l,
  input  logic              sensor_m,
  input  logic              sensor_r,
  input  logic              turn_done,
  output logic              turn_start,
  output logic [2:0]        turn_cmd,
  output logic [ADDR_W-1:0] node_idx,
  output logic              busy,
  output logic              route_done,
  output logic              timeout_err
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int LEN_W = ADDR_W + 1;
  localparam int DEB_W = $clog2(NODE_DEB + 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DEPTH);
  localparam logic [2:0]       CMD_STOP = 3'b000;
  localparam logic [2:0]       CMD_FWD  = 3'b001;

  if (NODE_DEB < 1 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("sb_route_sequencer: NODE_DEB and TIMEOUT_CYC must be >= 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FOLLOW,
    ST_TURN,
    ST_CLEAR,
    ST_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [DEB_W-1:0]   deb_q, deb_d;
  logic               err_q, err_d;
  logic               start_q, start_d;
  logic [2:0]         cmd_q, cmd_d;
  logic               done_q, done_d;
  logic [2:0]         tbl_q [DEPTH];

  logic               all_high;
  logic [2:0]         tbl_cur;
  logic               is_last;
  logic [LEN_W-1:0]   len_clamp;
  logic               tmo_hit;

  assign all_high  = sensor_l & sensor_m & sensor_r;
  assign tbl_cur   = tbl_q[idx_q];
  assign is_last   = ({1'b0, idx_q} + LEN_W'(1)) == len_q;
  assign len_clamp = (route_len > LEN_MAX) ? LEN_MAX : route_len;

  // Route table: writable only while idle, so a running route sees a frozen
  // table. A write coinciding with an accepted run lands before the first
  // turn is read, so that route uses the new entry.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= CMD_STOP;
    end else if (route_wr_en && state_q == ST_IDLE) begin
      tbl_q[route_wr_addr] <= route_wr_data;
    end
  end

`ifdef SB_TURN_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] tmr_q;

  // Down-counter preloaded outside TURN; terminal count on the last allowed
  // TURN cycle, so the FSM spends exactly TIMEOUT_CYC cycles in TURN.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst)                     tmr_q <= TMR_LOAD;
    else if (state_q != ST_TURN) tmr_q <= TMR_LOAD;
    else if (tmr_q != '0)        tmr_q <= tmr_q - TMR_W'(1);
  end

  assign tmo_hit = (state_q == ST_TURN) && (tmr_q == '0);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      deb_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      cmd_q   <= CMD_STOP;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      deb_q   <= deb_d;
      err_q   <= err_d;
      start_q <= start_d;
      cmd_q   <= cmd_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    deb_d   = '0;
    err_d   = err_q;
    done_d  = 1'b0;
    start_d = 1'b0;
    cmd_d   = CMD_STOP;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (run) begin
            if (route_len == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_FOLLOW;
              idx_d   = '0;
              len_d   = len_clamp;
              err_d   = 1'b0;
            end
          end
        end
        ST_FOLLOW: begin
          if (all_high) begin
            if (deb_q == DEB_W'(NODE_DEB - 1)) state_d = ST_TURN;
            else                               deb_d   = deb_q + DEB_W'(1);
          end
        end
        ST_TURN: begin
          if (tbl_cur == CMD_STOP) begin
            state_d = ST_FINISH;
          end else if (turn_done) begin
            if (is_last) begin
              state_d = ST_FINISH;
            end else begin
              idx_d   = idx_q + ADDR_W'(1);
              state_d = ST_CLEAR;
            end
          end else if (tmo_hit) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
        ST_CLEAR: begin
          if (!all_high) state_d = ST_FOLLOW;
        end
        ST_FINISH: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Outputs are decoded from the next state so that they register in step
    // with the state itself. A stop code in TURN never raises turn_start.
    unique case (state_d)
      ST_FOLLOW, ST_CLEAR: cmd_d = CMD_FWD;
      ST_TURN: begin
        cmd_d   = tbl_cur;
        start_d = (tbl_cur != CMD_STOP);
      end
      ST_FINISH: done_d = 1'b1;
      default: ;
    endcase
  end

  assign turn_start  = start_q;
  assign turn_cmd    = cmd_q;
  assign node_idx    = idx_q;
  assign busy        = (state_q != ST_IDLE);
  assign route_done  = done_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_sb_route_sequencer.sv
// Directed bench for sb_route_sequencer (ADDR_W=4, NODE_DEB=4, TIMEOUT_CYC=20).
// Inputs change 1 ns after the rising edge; outputs are checked at that point.

module tb_sb_route_sequencer;

  logic       clk_50 = 1'b0;
  logic       rst = 1'b1;
  logic       route_wr_en = 1'b0;
  logic [3:0] route_wr_addr = '0;
  logic [2:0] route_wr_data = '0;
  logic [4:0] route_len = '0;
  logic       run = 1'b0;
  logic       abort = 1'b0;
  logic       sensor_l = 1'b0, sensor_m = 1'b0, sensor_r = 1'b0;
  logic       turn_done = 1'b0;
  logic       turn_start;
  logic [2:0] turn_cmd;
  logic [3:0] node_idx;
  logic       busy, route_done, timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt  = 0;
  int left_cnt = 0;
  int rd0, l0;

  sb_route_sequencer #(.ADDR_W(4), .NODE_DEB(4), .TIMEOUT_CYC(20)) dut (
    .clk_50(clk_50), .rst(rst),
    .route_wr_en(route_wr_en), .route_wr_addr(route_wr_addr), .route_wr_data(route_wr_data),
    .route_len(route_len), .run(run), .abort(abort),
    .sensor_l(sensor_l), .sensor_m(sensor_m), .sensor_r(sensor_r),
    .turn_done(turn_done), .turn_start(turn_start), .turn_cmd(turn_cmd),
    .node_idx(node_idx), .busy(busy), .route_done(route_done), .timeout_err(timeout_err)
  );

  always #10 clk_50 = ~clk_50;

  always @(negedge clk_50) begin
    if (route_done) rd_cnt++;
    if (turn_start && turn_cmd == 3'b010) left_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50);
    #1;
  endtask

  task automatic set_sens(input logic [2:0] s);
    {sensor_l, sensor_m, sensor_r} = s;
  endtask

  task automatic wr(input logic [3:0] a, input logic [2:0] d);
    route_wr_en = 1'b1; route_wr_addr = a; route_wr_data = d;
    step();
    route_wr_en = 1'b0;
  endtask

  task automatic start_route(input logic [4:0] len);
    route_len = len; run = 1'b1;
    step();
    run = 1'b0;
  endtask

  // From FOLLOW with the debounce counter at 0: present a node for 4 cycles,
  // answer the turn 5 cycles after turn_start, and check the follow-on state.
  task automatic node_turn(input logic [2:0] exp_cmd, input logic [3:0] exp_idx, input bit last);
    set_sens(3'b111);
    repeat (3) step();
    chk("deb_no_start", turn_start, 0);
    step();
    chk("turn_start", turn_start, 1);
    chk("turn_cmd", turn_cmd, exp_cmd);
    chk("turn_idx", node_idx, exp_idx);
    set_sens(3'b000);
    repeat (4) step();
    chk("start_held", turn_start, 1);
    turn_done = 1'b1;
    step();
    turn_done = 1'b0;
    chk("start_drop", turn_start, 0);
    if (!last) begin
      chk("clear_cmd", turn_cmd, 3'b001);
      chk("idx_adv", node_idx, exp_idx + 4'd1);
      step();
    end else begin
      chk("fin_done", route_done, 1);
      chk("fin_busy", busy, 1);
      chk("fin_cmd", turn_cmd, 3'b000);
      step();
      chk("idle_done", route_done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_idx", node_idx, exp_idx);
    end
  endtask

  initial begin
    // reset state
    step(); step();
    chk("rst_start", turn_start, 0);
    chk("rst_cmd", turn_cmd, 0);
    chk("rst_idx", node_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", route_done, 0);
    chk("rst_err", timeout_err, 0);
    rst = 1'b0;
    step();

    // 1+2: three-node route with a 3-cycle all-high glitch first
    wr(0, 3'b010); wr(1, 3'b011); wr(2, 3'b001);
    rd0 = rd_cnt;
    start_route(5'd3);
    chk("t1_busy", busy, 1);
    chk("t1_cmd_fwd", turn_cmd, 3'b001);
    chk("t1_idx0", node_idx, 0);
    set_sens(3'b111);
    repeat (3) step();
    set_sens(3'b010);
    step();
    chk("glitch_start", turn_start, 0);
    chk("glitch_cmd", turn_cmd, 3'b001);
    node_turn(3'b010, 4'd0, 0);
    node_turn(3'b011, 4'd1, 0);
    node_turn(3'b001, 4'd2, 1);
    chk("t1_pulses", rd_cnt - rd0, 1);

    // 3: stop code at entry 1 ends the route early
    wr(0, 3'b011); wr(1, 3'b000); wr(2, 3'b010);
    rd0 = rd_cnt; l0 = left_cnt;
    start_route(5'd3);
    node_turn(3'b011, 4'd0, 0);
    set_sens(3'b111);
    repeat (4) step();
    set_sens(3'b000);
    chk("stop_start", turn_start, 0);
    chk("stop_cmd", turn_cmd, 3'b000);
    chk("stop_busy", busy, 1);
    step();
    chk("stop_done", route_done, 1);
    chk("stop_idx", node_idx, 1);
    step();
    chk("stop_idle", busy, 0);
    chk("t3_pulses", rd_cnt - rd0, 1);
    chk("t3_no_left", left_cnt - l0, 0);

    // 4: CLEAR holds on the same node, turn_done ignored in FOLLOW, abort mid-TURN
    wr(0, 3'b010); wr(1, 3'b011); wr(2, 3'b001);
    rd0 = rd_cnt;
    start_route(5'd3);
    set_sens(3'b111);
    repeat (4) step();
    chk("t4_start", turn_start, 1);
    repeat (2) step();
    turn_done = 1'b1;
    step();
    turn_done = 1'b0;
    chk("t4_clear_cmd", turn_cmd, 3'b001);
    repeat (5) step();
    chk("clear_hold_start", turn_start, 0);
    chk("clear_hold_idx", node_idx, 1);
    set_sens(3'b000);
    step();
    turn_done = 1'b1;
    step();
    turn_done = 1'b0;
    chk("stray_done_start", turn_start, 0);
    chk("stray_done_idx", node_idx, 1);
    set_sens(3'b111);
    repeat (4) step();
    set_sens(3'b000);
    chk("t4_turn2_cmd", turn_cmd, 3'b011);
    repeat (2) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_start", turn_start, 0);
    chk("abort_cmd", turn_cmd, 3'b000);
    step();
    chk("abort_no_done", rd_cnt - rd0, 0);
    start_route(5'd3);
    chk("rerun_idx", node_idx, 0);
    node_turn(3'b010, 4'd0, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // 5: turn_done never arrives
    rd0 = rd_cnt;
    start_route(5'd1);
    set_sens(3'b111);
    repeat (4) step();
    set_sens(3'b000);
    chk("t5_start", turn_start, 1);
    repeat (19) step();
    chk("t5_still_turn", turn_start, 1);
    chk("t5_err_early", timeout_err, 0);
    step();
`ifdef SB_TURN_TIMEOUT_EN
    chk("tmo_err", timeout_err, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_start", turn_start, 0);
    chk("tmo_cmd", turn_cmd, 3'b000);
    step();
    chk("tmo_no_done", rd_cnt - rd0, 0);
    start_route(5'd1);
    chk("tmo_err_clr", timeout_err, 0);
`else
    chk("notmo_start", turn_start, 1);
    chk("notmo_busy", busy, 1);
    chk("notmo_err", timeout_err, 0);
`endif
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_idle", busy, 0);

    // 6: zero-length run, write+run same cycle, reset mid-route
    route_len = 5'd0; run = 1'b1;
    step();
    run = 1'b0;
    chk("len0_done", route_done, 1);
    chk("len0_busy", busy, 0);
    step();
    chk("len0_pulse_end", route_done, 0);
    route_wr_en = 1'b1; route_wr_addr = 4'd0; route_wr_data = 3'b100;
    start_route(5'd1);
    route_wr_en = 1'b0;
    chk("wr_run_busy", busy, 1);
    node_turn(3'b100, 4'd0, 1);
    start_route(5'd3);
    set_sens(3'b111);
    repeat (4) step();
    set_sens(3'b000);
    chk("pre_rst_start", turn_start, 1);
    #5 rst = 1'b1;
    #1;
    chk("async_rst_start", turn_start, 0);
    chk("async_rst_cmd", turn_cmd, 0);
    chk("async_rst_busy", busy, 0);
    step(); step();
    rst = 1'b0;
    step();
    start_route(5'd1);
    set_sens(3'b111);
    repeat (4) step();
    set_sens(3'b000);
    chk("tbl_cleared_start", turn_start, 0);
    chk("tbl_cleared_cmd", turn_cmd, 3'b000);
    step();
    chk("tbl_cleared_done", route_done, 1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
